scan_duration_sender: RTL and testbench

SCAN_DURATION_SENDER -- requirements
Module: scan_duration_sender

---
 rtl/ovdp_cdc_pkg.sv | 22 ++
 rtl/scan_duration_sender_if.sv | 29 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/scan_duration_sender.sv | 159 +++++++++++++++
 tb/tb_scan_duration_sender.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ovdp_cdc_pkg.sv
// Shared definitions for the fast-domain scan-duration sender: state encoding,
// default configuration and a counter-width helper.
package ovdp_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_GAP
  } sender_state_e;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_REQ_CYCLES     = 64;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES    = 3;

  // Bits needed to count 0 .. n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_duration_sender_if.sv
// Offer / request-acknowledge bundle between the source, the sender and the
// slow destination.
interface scan_duration_sender_if
  import ovdp_cdc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_in;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data, ack_in,
    input  in_ready, req_out, data_out, busy, done, err
  );

  modport slave (
    input  in_valid, in_data, ack_in,
    output in_ready, req_out, data_out, busy, done, err
  );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops use non-blocking assignment so meta and q both see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/scan_duration_sender.sv
// Presents a coalesced value to a slow destination with a long req pulse and waits for ack.
// Timeout/retry behaviour is compiled in only when SCAN_SENDER_TIMEOUT_EN is defined.
module scan_duration_sender
  import ovdp_cdc_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input logic                   clk_fast,
  input logic                   reset,
  scan_duration_sender_if.slave bus
);

  localparam int              PH_W     = cnt_width(REQ_CYCLES);
  localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);

`ifdef SCAN_SENDER_TIMEOUT_EN
  localparam int               TMO_W      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int               RTY_W      = cnt_width(MAX_RETRIES + 1);
  localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRIES);

  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;
`endif

  sender_state_e     state;
  logic [PH_W-1:0]   phase_cnt;
  logic [DATA_W-1:0] pending;
  logic              pending_vld;
  logic              launch;
  logic              ack_sync;
  logic              ack_d;
  logic              ack_rise;

  assign bus.in_ready = 1'b1;

  sync_2ff u_ack_sync (
    .clk (clk_fast),
    .rst (reset),
    .d   (bus.ack_in),
    .q   (ack_sync)
  );

  // NOTE: reset is asynchronous, so it sits in the sensitivity list next to the clock.
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) ack_d <= 1'b0;
    else       ack_d <= ack_sync;
  end

  assign ack_rise = ack_sync & ~ack_d;
  assign launch   = (state == ST_IDLE) && pending_vld;

  // A fresh offer always overwrites the slot, even on the cycle the old value launches.
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      pending_vld <= 1'b0;
    end else if (bus.in_valid) begin
      pending     <= bus.in_data;
      pending_vld <= 1'b1;
    end else if (launch) begin
      pending_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase_cnt    <= '0;
      bus.req_out  <= 1'b0;
      bus.data_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
`ifdef SCAN_SENDER_TIMEOUT_EN
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      bus.err      <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef SCAN_SENDER_TIMEOUT_EN
      bus.err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pending_vld) begin
            bus.data_out <= pending;
            bus.req_out  <= 1'b1;
            bus.busy     <= 1'b1;
            phase_cnt    <= '0;
`ifdef SCAN_SENDER_TIMEOUT_EN
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
`endif
            state        <= ST_REQ;
          end
        end

        ST_REQ, ST_WAIT_ACK: begin
          if (ack_rise) begin
            bus.req_out <= 1'b0;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= ST_IDLE;
          end
`ifdef SCAN_SENDER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            bus.req_out <= 1'b0;
            phase_cnt   <= '0;
            if (retry_cnt == RETRY_LAST) begin
              bus.err  <= 1'b1;
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_GAP;
            end
          end
`endif
          else if (state == ST_REQ) begin
            if (phase_cnt == REQ_LAST) begin
              bus.req_out <= 1'b0;
              state       <= ST_WAIT_ACK;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
`ifdef SCAN_SENDER_TIMEOUT_EN
          // Saturating: the counter parks at the compare value and cannot wrap.
          if (tmo_cnt < TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end

`ifdef SCAN_SENDER_TIMEOUT_EN
        ST_GAP: begin
          if (phase_cnt == REQ_LAST) begin
            bus.req_out <= 1'b1;
            phase_cnt   <= '0;
            tmo_cnt     <= '0;
            state       <= ST_REQ;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SCAN_SENDER_TIMEOUT_EN
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_duration_sender.sv
// Self-checking bench for scan_duration_sender; retry scenarios run only when
// SCAN_SENDER_TIMEOUT_EN is defined.
module tb_scan_duration_sender;

  localparam int DW      = 32;
  localparam int REQ_C   = 64;
  localparam int TMO_C   = 1024;
  localparam int RETRIES = 3;
  localparam int PERIOD  = TMO_C + REQ_C;
`ifdef SCAN_SENDER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk_fast = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Offers injected while a transfer is in flight; the model keeps only the last one.
  int          mid_at  [2];
  logic [DW-1:0] mid_val [2];
  logic [DW-1:0] late_val;
  bit          late_vld;
  logic [DW-1:0] forbid;
  bit          forbid_en;
  int          forbid_hits;

  scan_duration_sender_if #(.DATA_W(DW)) bus ();

  scan_duration_sender #(
    .DATA_W         (DW),
    .REQ_CYCLES     (REQ_C),
    .TIMEOUT_CYCLES (TMO_C),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .clk_fast (clk_fast),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk_fast = ~clk_fast;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [DW-1:0] v);
    @(negedge clk_fast);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk_fast);
    bus.in_valid = 1'b0;
  endtask

  task automatic offer_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk_fast);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    @(negedge clk_fast);
    bus.in_data  = b;
    @(negedge clk_fast);
    bus.in_valid = 1'b0;
  endtask

  // Pulses ack for a few cycles and expects the block to stay completely quiet.
  task automatic ack_in_idle(input string tag);
    int act;
    act = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_fast);
      if ({bus.busy, bus.req_out, bus.done, bus.err} !== 4'b0000) act++;
      bus.ack_in = (i < 4);
    end
    bus.ack_in = 1'b0;
    check(tag, DW'(act), '0);
  endtask

  // One transfer, cycle 0 = first cycle req_out is high. ack_in rises on cycle
  // ack_off of attempt ack_attempt (-1: never); it is seen 3 cycles later.
  task automatic run_xfer(input logic [DW-1:0] exp_data, input int ack_attempt,
                          input int ack_off, input string tag);
    int w, ack_at, end_i;
    int req_bad, data_bad, busy_bad, done_bad, err_bad;
    bit use_ack, exp_req;
    use_ack  = (ack_attempt >= 0);
    ack_at   = ack_attempt * PERIOD + ack_off;
    end_i    = use_ack ? ack_at + 3 : RETRIES * PERIOD + TMO_C;
    req_bad  = 0; data_bad = 0; busy_bad = 0; done_bad = 0; err_bad = 0;
    late_vld = 1'b0;
    w = 0;
    while (bus.req_out !== 1'b1 && w < 16) begin
      @(negedge clk_fast);
      w++;
    end
    check({tag, "_start"}, DW'(bus.req_out), DW'(1));
    if (bus.req_out !== 1'b1) return;
    for (int i = 0; i <= end_i; i++) begin
      if (i > 0) @(negedge clk_fast);
      if (TMO_EN) exp_req = (i < end_i) && ((i % PERIOD) < REQ_C);
      else        exp_req = (i < end_i) && (i < REQ_C);
      if (bus.req_out  !== exp_req)                 req_bad++;
      if (bus.data_out !== exp_data)                data_bad++;
      if (bus.busy     !== (i < end_i))             busy_bad++;
      if (bus.done     !== (use_ack && i == end_i)) done_bad++;
      if (bus.err      !== (!use_ack && i == end_i)) err_bad++;
      if (forbid_en && bus.data_out === forbid)     forbid_hits++;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (i == mid_at[k]) begin
          bus.in_valid = 1'b1;
          bus.in_data  = mid_val[k];
          late_val     = mid_val[k];
          late_vld     = 1'b1;
        end
      end
      if (use_ack && i == ack_at) bus.ack_in = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.ack_in   = 1'b0;
    mid_at       = '{-1, -1};
    check({tag, "_req_bad_cycles"},  DW'(req_bad),  '0);
    check({tag, "_data_bad_cycles"}, DW'(data_bad), '0);
    check({tag, "_busy_bad_cycles"}, DW'(busy_bad), '0);
    check({tag, "_done_bad_cycles"}, DW'(done_bad), '0);
    check({tag, "_err_bad_cycles"},  DW'(err_bad),  '0);
  endtask

  initial begin
    int            w;
    int            d;
    bit            have_nxt;
    logic [DW-1:0] nxt;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack_in   = 1'b0;
    reset        = 1'b1;
    mid_at       = '{-1, -1};
    mid_val      = '{'0, '0};
    late_val     = '0;
    late_vld     = 1'b0;
    forbid       = '0;
    forbid_en    = 1'b0;
    forbid_hits  = 0;

    repeat (3) @(negedge clk_fast);
    check("rst_req_out",  DW'(bus.req_out),  '0);
    check("rst_data_out", bus.data_out,      '0);
    check("rst_busy",     DW'(bus.busy),     '0);
    check("rst_done",     DW'(bus.done),     '0);
    check("rst_err",      DW'(bus.err),      '0);
    check("rst_in_ready", DW'(bus.in_ready), DW'(1));
    reset = 1'b0;

    ack_in_idle("idle_ack_ignored");

    offer(32'h0000_1388);
    run_xfer(32'h0000_1388, 0, 20, "ack_200ns");
    offer(32'hCAFE_0001);
    run_xfer(32'hCAFE_0001, 0, 90, "ack_in_wait");

    // 0xB is overwritten by 0xC; 0xC lands on the very cycle 0xA completes.
    forbid    = 32'h0000_000B;
    forbid_en = 1'b1;
    offer(32'h0000_000A);
    mid_at  = '{5, 42};
    mid_val = '{32'h0000_000B, 32'h0000_000C};
    run_xfer(32'h0000_000A, 0, 40, "coal_a");
    run_xfer(32'h0000_000C, 0, 15, "coal_c");
    forbid_en = 1'b0;
    check("coal_b_never_out", DW'(forbid_hits), '0);

    offer_two(32'h1111_2222, 32'h3333_4444);
    run_xfer(32'h1111_2222, 0, 0, "idle_exit_a");
    run_xfer(32'h3333_4444, 0, 7, "idle_exit_b");

    have_nxt = 1'b0;
    nxt      = '0;
    for (int k = 0; k < 6; k++) begin
      if (!have_nxt) begin
        nxt = $urandom;
        offer(nxt);
      end
      d = int'($urandom_range(2 * REQ_C, 0));
      if ($urandom_range(1, 0) == 1) begin
        mid_at[0]  = int'($urandom_range(d + 2, 0));
        mid_val[0] = $urandom;
      end
      run_xfer(nxt, 0, d, "rand");
      have_nxt = late_vld;
      nxt      = late_val;
    end
    if (have_nxt) run_xfer(nxt, 0, 5, "rand_tail");

`ifdef SCAN_SENDER_TIMEOUT_EN
    offer(32'h0BAD_F00D);
    run_xfer(32'h0BAD_F00D, -1, 0, "no_ack_err");
    offer(32'h0600_0D03);
    d = int'($urandom_range(TMO_C - 3, 0));
    run_xfer(32'h0600_0D03, 2, d, "ack_third_try");
`endif

    offer(32'h5A5A_5A5A);
    w = 0;
    while (bus.req_out !== 1'b1 && w < 16) begin
      @(negedge clk_fast);
      w++;
    end
    check("midrst_start", DW'(bus.req_out), DW'(1));
    repeat (80) @(negedge clk_fast);
    #2 reset = 1'b1;
    #1;
    check("midrst_req_out",  DW'(bus.req_out), '0);
    check("midrst_data_out", bus.data_out,     '0);
    check("midrst_busy",     DW'(bus.busy),    '0);
    check("midrst_done",     DW'(bus.done),    '0);
    check("midrst_err",      DW'(bus.err),     '0);
    @(negedge clk_fast);
    reset = 1'b0;
    ack_in_idle("midrst_late_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
